// File: rtl/am_search_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// am_search_sequencer_pkg
// Shared definitions for the associative-memory search sequencer:
//   - FSM state encoding (IDLE / RUN / DRAIN / DONE)
//   - ADL label-range boundaries and ADL class codes
//   - helper functions deriving chunk count, chunk index width and
//     distance width from the hypervector geometry
//   - label -> ADL class mapping function
// No ports (package).
// ---------------------------------------------------------------------------
package am_search_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Inclusive label ranges for each ADL class; anything above ADL4_HI is class 5.
    localparam int ADL0_LO = 0;
    localparam int ADL0_HI = 7;
    localparam int ADL1_LO = 8;
    localparam int ADL1_HI = 22;
    localparam int ADL2_LO = 23;
    localparam int ADL2_HI = 36;
    localparam int ADL3_LO = 37;
    localparam int ADL3_HI = 49;
    localparam int ADL4_LO = 50;
    localparam int ADL4_HI = 65;

    localparam logic [2:0] ADL_CODE_0 = 3'd0;
    localparam logic [2:0] ADL_CODE_1 = 3'd1;
    localparam logic [2:0] ADL_CODE_2 = 3'd2;
    localparam logic [2:0] ADL_CODE_3 = 3'd3;
    localparam logic [2:0] ADL_CODE_4 = 3'd4;
    localparam logic [2:0] ADL_CODE_5 = 3'd5;

    function automatic int calcNumChunks(input int hvDim, input int chunkW);
        return hvDim / chunkW;
    endfunction

    // A single-chunk configuration still needs a 1-bit chunk address port.
    function automatic int calcChunkIdxW(input int numChunks);
        return (numChunks > 1) ? $clog2(numChunks) : 1;
    endfunction

    // Distance can reach HV_DIMENSION itself, hence the +1.
    function automatic int calcDistanceWidth(input int hvDim);
        return $clog2(hvDim + 1);
    endfunction

    function automatic logic [2:0] adlOfLabel(input int label);
        if (label >= ADL0_LO && label <= ADL0_HI) return ADL_CODE_0;
        if (label >= ADL1_LO && label <= ADL1_HI) return ADL_CODE_1;
        if (label >= ADL2_LO && label <= ADL2_HI) return ADL_CODE_2;
        if (label >= ADL3_LO && label <= ADL3_HI) return ADL_CODE_3;
        if (label >= ADL4_LO && label <= ADL4_HI) return ADL_CODE_4;
        return ADL_CODE_5;
    endfunction

endpackage

// File: rtl/am_search_sequencer_chunk_hamming.sv
// ---------------------------------------------------------------------------
// chunk_hamming
// Purely combinational Hamming distance of one chunk: popcount(query ^ proto).
// Ports:
//   queryChunk_i  in  CHUNK_WIDTH              query hypervector chunk
//   protoChunk_i  in  CHUNK_WIDTH              prototype chunk from AM ROM
//   distance_o    out clog2(CHUNK_WIDTH+1)     number of differing bits
// ---------------------------------------------------------------------------
module chunk_hamming #(
    parameter int CHUNK_WIDTH = 64
) (
    input  logic [CHUNK_WIDTH-1:0]             queryChunk_i,
    input  logic [CHUNK_WIDTH-1:0]             protoChunk_i,
    output logic [$clog2(CHUNK_WIDTH+1)-1:0]   distance_o
);

    localparam int POP_W = $clog2(CHUNK_WIDTH + 1);

    logic [CHUNK_WIDTH-1:0] diff;
    logic [POP_W-1:0]       count;

    assign diff = queryChunk_i ^ protoChunk_i;

    // Simple ripple popcount; synthesis rebalances it into an adder tree.
    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            count = count + POP_W'(diff[i]);
        end
    end

    assign distance_o = count;

endmodule

// File: rtl/am_search_sequencer.sv
// ---------------------------------------------------------------------------
// am_search_sequencer
// Time-multiplexed associative-memory classifier. One shared chunk Hamming
// unit is swept over every (row, chunk) of an external synchronous AM ROM;
// per-row distances are accumulated and the minimum-distance row is reported
// together with its ADL class.
// Ports:
//   Clk_CI            in   1               clock, rising edge
//   Reset_RI          in   1               async active-high reset
//   ValidIn_SI        in   1               query HV valid
//   ReadyOut_SO       out  1               high in IDLE (can accept HV)
//   HypervectorIn_DI  in   HV_DIMENSION    query HV, bit 0 = chunk 0 LSB
//   Flush_SI          in   1               synchronous abort of a search
//   ValidOut_SO       out  1               result valid
//   ReadyIn_SI        in   1               consumer accepts result
//   LabelOut_DO       out  LABEL_WIDTH     best label
//   DistanceOut_DO    out  DISTANCE_WIDTH  distance of best label
//   ADLOut_DO         out  ADL_WIDTH       ADL class of best label
//   RowRdEn_SO        out  1               ROM read strobe
//   RowAddr_DO        out  LABEL_WIDTH     ROM row address
//   ChunkAddr_DO      out  CHUNK_IDX_W     ROM chunk address
//   RowData_DI        in   CHUNK_WIDTH     ROM data, 1 cycle after strobe
// ---------------------------------------------------------------------------
module am_search_sequencer
    import am_search_sequencer_pkg::*;
#(
    parameter int HV_DIMENSION = 1024,
    parameter int CHUNK_WIDTH  = 64,
    parameter int NUM_LABELS   = 72,
    parameter int LABEL_WIDTH  = 7,
    parameter int ADL_WIDTH    = 3,
    localparam int NUM_CHUNKS     = calcNumChunks(HV_DIMENSION, CHUNK_WIDTH),
    localparam int CHUNK_IDX_W    = calcChunkIdxW(NUM_CHUNKS),
    localparam int DISTANCE_WIDTH = calcDistanceWidth(HV_DIMENSION)
) (
    input  logic                      Clk_CI,
    input  logic                      Reset_RI,
    input  logic                      ValidIn_SI,
    output logic                      ReadyOut_SO,
    input  logic [HV_DIMENSION-1:0]   HypervectorIn_DI,
    input  logic                      Flush_SI,
    output logic                      ValidOut_SO,
    input  logic                      ReadyIn_SI,
    output logic [LABEL_WIDTH-1:0]    LabelOut_DO,
    output logic [DISTANCE_WIDTH-1:0] DistanceOut_DO,
    output logic [ADL_WIDTH-1:0]      ADLOut_DO,
    output logic                      RowRdEn_SO,
    output logic [LABEL_WIDTH-1:0]    RowAddr_DO,
    output logic [CHUNK_IDX_W-1:0]    ChunkAddr_DO,
    input  logic [CHUNK_WIDTH-1:0]    RowData_DI
);

    localparam int POP_W = $clog2(CHUNK_WIDTH + 1);
    localparam logic [LABEL_WIDTH-1:0] LAST_ROW   = LABEL_WIDTH'(NUM_LABELS - 1);
    localparam logic [CHUNK_IDX_W-1:0] LAST_CHUNK = CHUNK_IDX_W'(NUM_CHUNKS - 1);

    state_t                    state_q;
    logic [HV_DIMENSION-1:0]   query_q;
    logic [LABEL_WIDTH-1:0]    row_q;
    logic [CHUNK_IDX_W-1:0]    chunk_q;

    // Read tag: describes the ROM word arriving on RowData_DI this cycle.
    logic                      tagVld_q;
    logic                      tagLast_q;
    logic [LABEL_WIDTH-1:0]    tagRow_q;
    logic [CHUNK_IDX_W-1:0]    tagChunk_q;

    logic [DISTANCE_WIDTH-1:0] acc_q;
    logic [DISTANCE_WIDTH-1:0] bestDist_q;
    logic [LABEL_WIDTH-1:0]    bestLabel_q;

    logic                      validOut_q;
    logic [LABEL_WIDTH-1:0]    labelOut_q;
    logic [DISTANCE_WIDTH-1:0] distOut_q;
    logic [ADL_WIDTH-1:0]      adlOut_q;

    logic [CHUNK_WIDTH-1:0]    queryChunk_d;
    logic [POP_W-1:0]          chunkDist_d;
    logic [DISTANCE_WIDTH-1:0] accSum_d;
    logic                      bestUpdate_d;

    // The query chunk is selected by the returning tag, not the issue address,
    // so it lines up with the ROM word it is compared against.
    assign queryChunk_d = query_q[tagChunk_q*CHUNK_WIDTH +: CHUNK_WIDTH];

    chunk_hamming #(
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_chunk_hamming (
        .queryChunk_i (queryChunk_d),
        .protoChunk_i (RowData_DI),
        .distance_o   (chunkDist_d)
    );

    // Chunk 0 of a row restarts the accumulation.
    assign accSum_d = ((tagChunk_q == '0) ? '0 : acc_q) + DISTANCE_WIDTH'(chunkDist_d);

    // Row 0 seeds the minimum; later rows win only on a strictly smaller
    // distance, so ties keep the lower label.
    assign bestUpdate_d = tagVld_q && tagLast_q &&
                          ((tagRow_q == '0) || (accSum_d < bestDist_q));

    assign ReadyOut_SO    = (state_q == ST_IDLE);
    assign RowRdEn_SO     = (state_q == ST_RUN);
    assign RowAddr_DO     = row_q;
    assign ChunkAddr_DO   = chunk_q;
    assign ValidOut_SO    = validOut_q;
    assign LabelOut_DO    = labelOut_q;
    assign DistanceOut_DO = distOut_q;
    assign ADLOut_DO      = adlOut_q;

    // Single sequential block: FSM, address counters, read-tag pipeline,
    // accumulator, minimum tracker and registered result outputs. DRAIN waits
    // for the tag pipeline to empty so the final row's result is folded into
    // the minimum before the outputs are loaded on entry to DONE.
    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state_q     <= ST_IDLE;
            query_q     <= '0;
            row_q       <= '0;
            chunk_q     <= '0;
            tagVld_q    <= 1'b0;
            tagLast_q   <= 1'b0;
            tagRow_q    <= '0;
            tagChunk_q  <= '0;
            acc_q       <= '0;
            bestDist_q  <= '0;
            bestLabel_q <= '0;
            validOut_q  <= 1'b0;
            labelOut_q  <= '0;
            distOut_q   <= '0;
            adlOut_q    <= '0;
        end else if (Flush_SI && (state_q != ST_IDLE)) begin
            state_q    <= ST_IDLE;
            tagVld_q   <= 1'b0;
            validOut_q <= 1'b0;
        end else begin
            tagVld_q   <= (state_q == ST_RUN);
            tagRow_q   <= row_q;
            tagChunk_q <= chunk_q;
            tagLast_q  <= (chunk_q == LAST_CHUNK);

            if (tagVld_q) begin
                acc_q <= accSum_d;
            end
            if (bestUpdate_d) begin
                bestLabel_q <= tagRow_q;
                bestDist_q  <= accSum_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (ValidIn_SI) begin
                        query_q <= HypervectorIn_DI;
                        row_q   <= '0;
                        chunk_q <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (chunk_q == LAST_CHUNK) begin
                        chunk_q <= '0;
                        if (row_q == LAST_ROW) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end else begin
                        chunk_q <= chunk_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!tagVld_q) begin
                        state_q    <= ST_DONE;
                        validOut_q <= 1'b1;
                        labelOut_q <= bestLabel_q;
                        distOut_q  <= bestDist_q;
                        adlOut_q   <= ADL_WIDTH'(adlOfLabel(int'(bestLabel_q)));
                    end
                end
                ST_DONE: begin
                    if (ReadyIn_SI) begin
                        state_q    <= ST_IDLE;
                        validOut_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_am_search_sequencer.sv
// ---------------------------------------------------------------------------
// tb_am_search_sequencer
// Directed self-checking bench for am_search_sequencer with a behavioural
// synchronous AM ROM. All inputs change and outputs are sampled 1 ns after
// the rising clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_am_search_sequencer;

    localparam int HV_DIM     = 1024;
    localparam int CHUNK_W    = 64;
    localparam int NUM_LABELS = 72;
    localparam int EXP_LAT    = 1154;
    localparam int EXP_RD     = 1152;

    logic              clk = 1'b0;
    logic              Reset_RI = 1'b0;
    logic              ValidIn_SI = 1'b0;
    logic              ReadyOut_SO;
    logic [HV_DIM-1:0] HypervectorIn_DI = '0;
    logic              Flush_SI = 1'b0;
    logic              ValidOut_SO;
    logic              ReadyIn_SI = 1'b0;
    logic [6:0]        LabelOut_DO;
    logic [10:0]       DistanceOut_DO;
    logic [2:0]        ADLOut_DO;
    logic              RowRdEn_SO;
    logic [6:0]        RowAddr_DO;
    logic [3:0]        ChunkAddr_DO;
    logic [CHUNK_W-1:0] RowData_DI = '0;

    logic [HV_DIM-1:0] romRows [NUM_LABELS];

    int checkCount = 0;
    int errorCount = 0;

    am_search_sequencer dut (
        .Clk_CI           (clk),
        .Reset_RI         (Reset_RI),
        .ValidIn_SI       (ValidIn_SI),
        .ReadyOut_SO      (ReadyOut_SO),
        .HypervectorIn_DI (HypervectorIn_DI),
        .Flush_SI         (Flush_SI),
        .ValidOut_SO      (ValidOut_SO),
        .ReadyIn_SI       (ReadyIn_SI),
        .LabelOut_DO      (LabelOut_DO),
        .DistanceOut_DO   (DistanceOut_DO),
        .ADLOut_DO        (ADLOut_DO),
        .RowRdEn_SO       (RowRdEn_SO),
        .RowAddr_DO       (RowAddr_DO),
        .ChunkAddr_DO     (ChunkAddr_DO),
        .RowData_DI       (RowData_DI)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Synchronous AM ROM: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (RowRdEn_SO) begin
            RowData_DI <= romRows[RowAddr_DO][ChunkAddr_DO*CHUNK_W +: CHUNK_W];
        end
    end

    // Pseudo-random row pattern from a xorshift generator seeded by k.
    function automatic logic [HV_DIM-1:0] lfsrRow(input int k);
        logic [31:0]       s;
        logic [HV_DIM-1:0] r;
        s = 32'h0000_ACE1 + 32'(k) * 32'h9E37_79B9;
        r = '0;
        for (int i = 0; i < HV_DIM/32; i++) begin
            s = s ^ (s << 13);
            s = s ^ (s >> 17);
            s = s ^ (s << 5);
            r[i*32 +: 32] = s;
        end
        return r;
    endfunction

    task automatic fillLfsrRom();
        for (int k = 0; k < NUM_LABELS; k++) romRows[k] = lfsrRow(k);
    endtask

    // Count one comparison and report a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Offer one query HV, wait (bounded) for the result and check it,
    // including latency and the number of ROM read cycles. Entered and left
    // 1 ns after a rising edge. With doRelease the result is consumed.
    task automatic applyStimulus(input string tag, input logic [HV_DIM-1:0] hv,
                                 input int expLabel, input int expDist, input int expAdl,
                                 input bit doRelease);
        int latency;
        int rdCycles;
        bit done;
        checkOutput({tag, "_ready_before"}, 32'(ReadyOut_SO), 1);
        HypervectorIn_DI = hv;
        ValidIn_SI       = 1'b1;
        @(posedge clk); #1;
        ValidIn_SI       = 1'b0;
        HypervectorIn_DI = ~hv;
        latency  = 0;
        rdCycles = 0;
        done     = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (RowRdEn_SO) rdCycles++;
            if (ValidOut_SO) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                latency++;
            end
        end
        checkOutput({tag, "_done"},     32'(done), 1);
        checkOutput({tag, "_latency"},  32'(latency), EXP_LAT);
        checkOutput({tag, "_rdcycles"}, 32'(rdCycles), EXP_RD);
        checkOutput({tag, "_label"},    32'(LabelOut_DO), 32'(expLabel));
        checkOutput({tag, "_distance"}, 32'(DistanceOut_DO), 32'(expDist));
        checkOutput({tag, "_adl"},      32'(ADLOut_DO), 32'(expAdl));
        if (doRelease) begin
            ReadyIn_SI = 1'b1;
            @(posedge clk); #1;
            ReadyIn_SI = 1'b0;
            checkOutput({tag, "_idle_after"}, 32'(ReadyOut_SO), 1);
            checkOutput({tag, "_vout_after"}, 32'(ValidOut_SO), 0);
        end
    endtask

    initial begin
        logic [HV_DIM-1:0] hv;
        logic [HV_DIM-1:0] mask;
        bit found;
        bit sawRd;
        bit sawValid;

        // ---------------- reset state ----------------
        fillLfsrRom();
        #1 Reset_RI = 1'b1;
        #1;
        checkOutput("rst_ready",   32'(ReadyOut_SO), 1);
        checkOutput("rst_vout",    32'(ValidOut_SO), 0);
        checkOutput("rst_rden",    32'(RowRdEn_SO), 0);
        checkOutput("rst_rowaddr", 32'(RowAddr_DO), 0);
        checkOutput("rst_label",   32'(LabelOut_DO), 0);
        checkOutput("rst_dist",    32'(DistanceOut_DO), 0);
        checkOutput("rst_adl",     32'(ADLOut_DO), 0);
        @(posedge clk); @(posedge clk); #1;
        Reset_RI = 1'b0;
        @(posedge clk); #1;

        // ---------------- exact match on row 41 ----------------
        applyStimulus("t1", romRows[41], 41, 0, 3, 1'b0);

        // ---------------- backpressure in DONE ----------------
        for (int i = 0; i < 10; i++) begin
            ValidIn_SI       = (i % 2 == 0);
            HypervectorIn_DI = lfsrRow(300 + i);
            @(posedge clk); #1;
            checkOutput("t4_vout_hold",  32'(ValidOut_SO), 1);
            checkOutput("t4_ready_low",  32'(ReadyOut_SO), 0);
            checkOutput("t4_label_hold", 32'(LabelOut_DO), 41);
            checkOutput("t4_dist_hold",  32'(DistanceOut_DO), 0);
            checkOutput("t4_adl_hold",   32'(ADLOut_DO), 3);
        end
        ValidIn_SI = 1'b0;
        ReadyIn_SI = 1'b1;
        @(posedge clk); #1;
        ReadyIn_SI = 1'b0;
        checkOutput("t4_ready_release", 32'(ReadyOut_SO), 1);
        checkOutput("t4_vout_release",  32'(ValidOut_SO), 0);
        @(posedge clk); #1;
        checkOutput("t4_no_accept", 32'(ReadyOut_SO), 1);

        // ---------------- tie between rows 5 and 9 ----------------
        hv   = lfsrRow(200);
        mask = '0;
        mask[0]    = 1'b1;
        mask[500]  = 1'b1;
        mask[1023] = 1'b1;
        romRows[5] = hv ^ mask;
        romRows[9] = hv ^ mask;
        applyStimulus("t2", hv, 5, 3, 0, 1'b1);

        // ---------------- all-zero ROM vs all-ones HV ----------------
        for (int k = 0; k < NUM_LABELS; k++) romRows[k] = '0;
        hv = '1;
        applyStimulus("t3a", hv, 0, 1024, 0, 1'b1);
        romRows[71] = hv;
        romRows[71][700] = 1'b0;
        applyStimulus("t3b", hv, 71, 1, 5, 1'b1);

        // ---------------- async reset mid-RUN ----------------
        fillLfsrRom();
        HypervectorIn_DI = romRows[41];
        ValidIn_SI       = 1'b1;
        @(posedge clk); #1;
        ValidIn_SI = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (RowRdEn_SO && RowAddr_DO == 7'd30) begin
                found = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        checkOutput("t5_reach_row30", 32'(found), 1);
        #2 Reset_RI = 1'b1;
        #1;
        checkOutput("t5_rst_vout",  32'(ValidOut_SO), 0);
        checkOutput("t5_rst_rden",  32'(RowRdEn_SO), 0);
        checkOutput("t5_rst_ready", 32'(ReadyOut_SO), 1);
        @(posedge clk); #1;
        Reset_RI = 1'b0;
        @(posedge clk); #1;
        applyStimulus("t5_after", romRows[41], 41, 0, 3, 1'b1);

        // ---------------- flush during DRAIN ----------------
        HypervectorIn_DI = romRows[41];
        ValidIn_SI       = 1'b1;
        @(posedge clk); #1;
        ValidIn_SI = 1'b0;
        sawRd = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (RowRdEn_SO) sawRd = 1'b1;
            if (sawRd && !RowRdEn_SO) begin
                found = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        checkOutput("t6_reach_drain", 32'(found), 1);
        Flush_SI = 1'b1;
        @(posedge clk); #1;
        Flush_SI = 1'b0;
        checkOutput("t6_drain_ready", 32'(ReadyOut_SO), 1);
        sawValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (ValidOut_SO) sawValid = 1'b1;
            @(posedge clk); #1;
        end
        checkOutput("t6_drain_no_vout", 32'(sawValid), 0);
        applyStimulus("t6_after_drain", romRows[17], 17, 0, 1, 1'b1);

        // ---------------- flush together with ReadyIn in DONE ----------------
        applyStimulus("t6_done", romRows[60], 60, 0, 4, 1'b0);
        Flush_SI   = 1'b1;
        ReadyIn_SI = 1'b1;
        @(posedge clk); #1;
        Flush_SI   = 1'b0;
        ReadyIn_SI = 1'b0;
        checkOutput("t6_done_ready", 32'(ReadyOut_SO), 1);
        checkOutput("t6_done_vout",  32'(ValidOut_SO), 0);
        applyStimulus("t6_after_done", romRows[30], 30, 0, 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/am_search_sequencer.md
Name: am_search_sequencer

Overview:
- Time-multiplexed controller for associative-memory classification: sequences one shared CHUNK_WIDTH-bit XOR/popcount unit across all prototype rows, chunk by chunk, instead of one fully parallel Hamming tree per label.
- Reads prototype chunks from an external synchronous AM ROM and accumulates per-row distance.
- Tracks the running minimum and returns best label, its distance and its ADL class.
- Sits between the encoder (HV producer) and the prosthetic command logic (result consumer).

Parameters:
HV_DIMENSION, 1024, hypervector width; must be a multiple of CHUNK_WIDTH
CHUNK_WIDTH, 64, bits compared per cycle
NUM_LABELS, 72, prototype rows in AM ROM
LABEL_WIDTH, 7, clog2(NUM_LABELS)
ADL_WIDTH, 3, ADL class code width
(derived) NUM_CHUNKS = HV_DIMENSION/CHUNK_WIDTH; CHUNK_IDX_W = max(1,clog2(NUM_CHUNKS)); DISTANCE_WIDTH = clog2(HV_DIMENSION+1)

Ports:
Clk_CI  in  1  single clock, rising edge
Reset_RI  in  1  asynchronous, active-high reset
ValidIn_SI  in  1  input HV valid
ReadyOut_SO  out  1  block can accept an HV
HypervectorIn_DI  in  HV_DIMENSION  query HV, bit 0 = chunk 0 LSB
Flush_SI  in  1  synchronous abort, drops current search
ValidOut_SO  out  1  result valid
ReadyIn_SI  in  1  consumer accepts result
LabelOut_DO  out  LABEL_WIDTH  best label index
DistanceOut_DO  out  DISTANCE_WIDTH  Hamming distance of best label
ADLOut_DO  out  ADL_WIDTH  ADL class of best label
RowRdEn_SO  out  1  AM ROM read strobe
RowAddr_DO  out  LABEL_WIDTH  ROM row address
ChunkAddr_DO  out  CHUNK_IDX_W  ROM chunk address
RowData_DI  in  CHUNK_WIDTH  ROM data, valid exactly 1 cycle after RowRdEn_SO

Behaviour:
- Reset (async, immediate): state IDLE; ValidOut_SO=0, RowRdEn_SO=0, RowAddr_DO/ChunkAddr_DO=0, LabelOut_DO/DistanceOut_DO/ADLOut_DO=0, read-tag pipeline cleared. ReadyOut_SO = (state==IDLE), so it reads 1 during reset.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on ValidIn_SI & ReadyOut_SO, latch HV into query register; row=0, chunk=0; -> RUN.
- RUN, every cycle:
  - RowRdEn_SO=1 with address (row,chunk).
  - chunk++; at NUM_CHUNKS-1, chunk wraps to 0 and row++.
  - After issuing (NUM_LABELS-1, NUM_CHUNKS-1) -> DRAIN.
- Read tag pipeline: registered (vld, row, chunk, last) delayed 1 cycle to align with RowData_DI.
- Accumulate on tagged return: d = popcount(RowData_DI ^ query chunk). acc <= (chunk==0 ? 0 : acc) + d. Width DISTANCE_WIDTH; no overflow possible.
- On last chunk of a row, with final = acc + d:
  - Row 0 unconditionally loads best.
  - Otherwise update only if final < best (strict); ties keep the lower index.
- DRAIN: consumes the final return, then -> DONE.
- DONE:
  - ValidOut_SO=1; LabelOut/DistanceOut/ADLOut registered and held stable until ReadyIn_SI.
  - On ValidOut_SO & ReadyIn_SI -> IDLE; the next HV is accepted no earlier than the following cycle.
- Latency: accept at edge t; RUN occupies NUM_LABELS*NUM_CHUNKS cycles; ValidOut_SO rises at edge t+NUM_LABELS*NUM_CHUNKS+2 (1154 cycles at defaults).
- ReadyOut_SO=0 in RUN/DRAIN/DONE. ValidIn_SI there is ignored, and HypervectorIn_DI may change freely after acceptance.
- ADL map: label 0-7 ->0, 8-22 ->1, 23-36 ->2, 37-49 ->3, 50-65 ->4, else 5. Computed from the final best label when entering DONE.
- Flush_SI (any non-IDLE state): next state IDLE, RowRdEn_SO=0, tag pipeline cleared, no ValidOut. Flush in IDLE has no effect. Flush has priority over ReadyIn_SI in DONE and over a same-cycle transition into DONE.
- Output registers are updated only on entry to DONE; earlier results are not visible mid-search.

Decomposition:
- Shared package/header:
  - ADL range constants (0,7,8,22,23,36,37,49,50,65) and ADL codes 0-5.
  - State encoding (2-bit IDLE/RUN/DRAIN/DONE).
  - DISTANCE_WIDTH and NUM_CHUNKS derivation macros.
- One natural sub-module: chunk_hamming, purely combinational. Inputs: CHUNK_WIDTH query and prototype chunks. Output: popcount of XOR, clog2(CHUNK_WIDTH+1) bits.
- FSM, counters, accumulator, minimum tracker and ADL map stay in am_search_sequencer.

Test Plan:
1. ROM row k = LFSR(k); HV = row 41 -> Label 41, Distance 0, ADL 3; ValidOut_SO at exactly 1154 cycles after accept; RowRdEn_SO high for exactly 1152 cycles.
2. Rows 5 and 9 identical, each 3 bits from HV, all others ≥10 -> Label 5, Distance 3, ADL 0 (tie keeps lower index).
3. All rows zero, HV all ones -> Distance 1024, Label 0, ADL 0. Then row 71 = HV with 1 bit flipped -> Label 71, Distance 1, ADL 5.
4. Hold ReadyIn_SI=0 for 10 cycles in DONE while pulsing ValidIn_SI -> outputs stable, ReadyOut_SO=0, no accept. ReadyIn_SI=1 -> IDLE next cycle, ReadyOut_SO=1.
5. Assert Reset_RI asynchronously mid-RUN (row 30) -> same instant ValidOut_SO=0, RowRdEn_SO=0, ReadyOut_SO=1. A fresh search then returns correct label 41.
6. Flush_SI during DRAIN, and separately during DONE together with ReadyIn_SI -> no ValidOut handshake, IDLE next cycle, next search correct.
